// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read arbiter.
package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam int ARLEN_W = 8;
    localparam int ARID_W  = 4;

    // Requester indices
    localparam int REQ_DCACHE = 0;
    localparam int REQ_ICACHE = 1;
    localparam int REQ_SBUF   = 2;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection for the read arbiter.
// ARB_ROUND_ROBIN_EN: when defined, search starts one past ptr (round robin);
// otherwise the lowest requesting index wins and ptr is ignored.
module arb_picker #(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

`ifdef ARB_ROUND_ROBIN_EN
    int         cand;
    logic [IDX_W-1:0] cand_idx;
    logic       found;

    // First requesting index at or after ptr+1, wrapping modulo NUM_REQ
    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand     = (int'(ptr) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end
`else
    logic       found;
    logic       unused_ptr;

    assign unused_ptr = ^ptr;

    // Lowest requesting index wins
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[IDX_W'(i)]) begin
                found              = 1'b1;
                grant[IDX_W'(i)]   = 1'b1;
                idx                = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Read arbiter: shares one memory read port among NUM_REQ requesters,
// one burst outstanding at a time. Optional round-robin via ARB_ROUND_ROBIN_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no transaction; pick a winner from req_arvalid
// ST_ADDR | presenting latched address on m_ar*, waiting for m_arready
// ST_DATA | forwarding beats to owner until the last beat of the burst
module axi_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_arvalid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_araddr,
    input  logic [NUM_REQ-1:0][ARLEN_W-1:0]   req_arlen,
    input  logic [NUM_REQ-1:0][ARID_W-1:0]    req_arid,
    output logic [NUM_REQ-1:0]                req_arready,
    output logic [NUM_REQ-1:0]                req_rvalid,
    output logic [DATA_W-1:0]                 req_rdata,
    output logic [ARID_W-1:0]                 req_rid,
    output logic                              m_arvalid,
    output logic [ADDR_W-1:0]                 m_araddr,
    output logic [ARLEN_W-1:0]                m_arlen,
    output logic [ARID_W-1:0]                 m_arid,
    input  logic                              m_arready,
    input  logic                              m_rvalid,
    input  logic [DATA_W-1:0]                 m_rdata,
    input  logic [ARID_W-1:0]                 m_rid,
    output logic                              m_rready,
    output logic                              busy,
    output logic [$clog2(NUM_REQ)-1:0]        owner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [ADDR_W-1:0]   lat_addr, sel_addr;
    logic [ARLEN_W-1:0]  lat_len, sel_len;
    logic [ARID_W-1:0]   lat_id, sel_id;
    logic [ARLEN_W-1:0]  beat_cnt;
    logic [ARLEN_W-1:0]  last_idx;
    logic                any_req;
    logic                last_beat;

    assign any_req   = |req_arvalid;
    // len 0 is served as a single beat, same as len 1
    assign last_idx  = (lat_len == '0) ? '0 : lat_len - 1'b1;
    assign last_beat = (state == ST_DATA) && m_rvalid && (beat_cnt == last_idx);

    arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req_arvalid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // One-hot mux of the winning requester's address fields
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_addr = sel_addr | req_araddr[i];
                sel_len  = sel_len  | req_arlen[i];
                sel_id   = sel_id   | req_arid[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and channel outputs; routing depends on owner only, never m_rid
    always_comb begin
        state_nxt   = state;
        req_arready = '0;
        req_rvalid  = '0;
        req_rdata   = '0;
        req_rid     = '0;
        m_arvalid   = 1'b0;
        m_araddr    = '0;
        m_arlen     = '0;
        m_arid      = '0;
        m_rready    = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (any_req) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                m_arvalid          = 1'b1;
                m_araddr           = lat_addr;
                m_arlen            = lat_len;
                m_arid             = lat_id;
                req_arready[owner] = m_arready;
                if (m_arready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                m_rready          = 1'b1;
                req_rvalid[owner] = m_rvalid;
                req_rdata         = m_rdata;
                req_rid           = m_rid;
                if (last_beat) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant latch and beat counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner    <= '0;
            lat_addr <= '0;
            lat_len  <= '0;
            lat_id   <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == ST_IDLE && any_req) begin
                owner    <= pick_idx;
                lat_addr <= sel_addr;
                lat_len  <= sel_len;
                lat_id   <= sel_id;
            end
            if (state == ST_ADDR && m_arready)
                beat_cnt <= '0;
            else if (state == ST_DATA && m_rvalid)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer remembers the last winner
    always_ff @(posedge clk) begin
        if (!rst_n)                        rr_ptr <= '0;
        else if (state == ST_IDLE && any_req) rr_ptr <= pick_idx;
    end
`else
    assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter; follows ARB_ROUND_ROBIN_EN if defined.
module tb_axi_read_arbiter;
    import mem_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       req_arvalid;
    logic [2:0][31:0] req_araddr;
    logic [2:0][7:0]  req_arlen;
    logic [2:0][3:0]  req_arid;
    logic [2:0]       req_arready;
    logic [2:0]       req_rvalid;
    logic [31:0]      req_rdata;
    logic [3:0]       req_rid;
    logic             m_arvalid;
    logic [31:0]      m_araddr;
    logic [7:0]       m_arlen;
    logic [3:0]       m_arid;
    logic             m_arready;
    logic             m_rvalid;
    logic [31:0]      m_rdata;
    logic [3:0]       m_rid;
    logic             m_rready;
    logic             busy;
    logic [1:0]       owner;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    always #5 clk = ~clk;

    axi_read_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arid(req_arid), .req_arready(req_arready), .req_rvalid(req_rvalid),
        .req_rdata(req_rdata), .req_rid(req_rid),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rid(m_rid),
        .m_rready(m_rready), .busy(busy), .owner(owner)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner rule: scan upward from start, wrapping; start is ptr+1 for round robin, 0 for fixed priority
    function automatic int model_pick(input logic [2:0] v, input int ptr);
        int start;
        start = RR ? ptr + 1 : 0;
        for (int k = 0; k < 3; k++)
            if (v[(start + k) % 3]) return (start + k) % 3;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        req_araddr[i]  = a;
        req_arlen[i]   = l;
        req_arid[i]    = id;
        req_arvalid[i] = 1'b1;
    endtask

    // Plays memory for one burst; called at an IDLE cycle, returns at the following IDLE cycle
    task automatic serve_one(input int ar_wait, input bit drop_early, input bit rereq,
                             input int abort_after, output int won);
        int w, nexp, beats, waited;
        logic [31:0] ea, d;
        logic [7:0]  el;
        logic [3:0]  ei, id;
        logic [2:0]  mask;
        bit          v;
        w = model_pick(req_arvalid, model_ptr);
        won = w;
        if (w < 0) begin
            check("pending_request", 64'd0, 64'd1);
            return;
        end
        mask = 3'(1 << w);
        ea = req_araddr[w]; el = req_arlen[w]; ei = req_arid[w];
        nexp = (el == 0) ? 1 : int'(el);
        waited = 0;
        do begin
            @(negedge clk); #1; waited++;
        end while (m_arvalid !== 1'b1 && waited < 10);
        check("ar_latency", 64'(waited), 64'd1);
        check("owner", 64'(owner), 64'(w));
        check("busy_addr", 64'(busy), 64'd1);
        check("rvalid_in_addr", 64'(req_rvalid), 64'd0);
        check("rready_in_addr", 64'(m_rready), 64'd0);
        model_ptr = w;
        if (drop_early) req_arvalid[w] = 1'b0;
        for (int k = 0; k < ar_wait; k++) begin
            m_arready = 1'b0; #1;
            check("arvalid_hold", 64'(m_arvalid), 64'd1);
            check("araddr_stable", 64'(m_araddr), 64'(ea));
            check("arlen_stable", 64'(m_arlen), 64'(el));
            check("arid_stable", 64'(m_arid), 64'(ei));
            check("arready_low", 64'(req_arready), 64'd0);
            @(negedge clk); #1;
        end
        m_arready = 1'b1; #1;
        check("araddr", 64'(m_araddr), 64'(ea));
        check("arready_pulse", 64'(req_arready), 64'(mask));
        @(negedge clk); #1;
        m_arready = 1'b0;
        if (rereq) set_req(w, $urandom, 8'($urandom_range(0, 5)), 4'($urandom));
        else       req_arvalid[w] = 1'b0;
        beats = 0;
        for (int c = 0; c < 200 && beats < nexp; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            v  = ($urandom_range(0, 2) != 0);
            d  = $urandom;
            id = ($urandom_range(0, 3) == 0) ? (ei ^ 4'h5) : ei;
            m_rvalid = v; m_rdata = d; m_rid = id; #1;
            check("rready_data", 64'(m_rready), 64'd1);
            check("arvalid_data", 64'(m_arvalid), 64'd0);
            check("arready_data", 64'(req_arready), 64'd0);
            check("rvalid_route", 64'(req_rvalid), v ? 64'(mask) : 64'd0);
            check("rdata", 64'(req_rdata), 64'(d));
            check("rid", 64'(req_rid), 64'(id));
            if (v) beats++;
            if (abort_after > 0 && beats == abort_after) break;
        end
        if (abort_after > 0) begin
            check("beats_before_reset", 64'(beats), 64'(abort_after));
            @(negedge clk); #1;
            rst_n = 1'b0; m_rvalid = 1'b1; m_rdata = $urandom;
            @(negedge clk); #1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_rvalid", 64'(req_rvalid), 64'd0);
            check("rst_rready", 64'(m_rready), 64'd0);
            check("rst_owner", 64'(owner), 64'd0);
            check("rst_arvalid", 64'(m_arvalid), 64'd0);
            @(negedge clk); #1;
            rst_n = 1'b1; model_ptr = 0;
            @(negedge clk); #1;
            check("post_rst_rvalid", 64'(req_rvalid), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
            m_rvalid = 1'b0;
            return;
        end
        check("beat_count", 64'(beats), 64'(nexp));
        @(negedge clk); #1;
        m_rvalid = 1'b1; m_rdata = $urandom; #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_rready", 64'(m_rready), 64'd0);
        check("idle_rvalid", 64'(req_rvalid), 64'd0);
        check("idle_arvalid", 64'(m_arvalid), 64'd0);
    endtask

    int won, w0, w1;
    int rr_exp[4] = '{REQ_ICACHE, REQ_SBUF, REQ_DCACHE, REQ_ICACHE};
    int n;

    initial begin
        rst_n = 1'b0; req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_arid = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_arvalid", 64'(m_arvalid), 64'd0);
        check("reset_owner", 64'(owner), 64'd0);
        check("reset_arready", 64'(req_arready), 64'd0);
        check("reset_rvalid", 64'(req_rvalid), 64'd0);
        check("reset_rready", 64'(m_rready), 64'd0);
        check("reset_araddr", 64'(m_araddr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // i-cache alone, 4 beats, immediate accept
        set_req(REQ_ICACHE, 32'h0000_0400, 8'd4, 4'h3);
        serve_one(0, 1'b0, 1'b0, 0, won);
        check("single_owner", 64'(won), 64'(REQ_ICACHE));

        // d-cache and stream buffer together
        set_req(REQ_DCACHE, 32'h1000_0000, 8'd2, 4'h1);
        set_req(REQ_SBUF,   32'h2000_0040, 8'd3, 4'h2);
        serve_one(0, 1'b0, 1'b0, 0, w0);
        serve_one(0, 1'b0, 1'b0, 0, w1);
`ifndef ARB_ROUND_ROBIN_EN
        check("prio_first", 64'(w0), 64'(REQ_DCACHE));
        check("prio_second", 64'(w1), 64'(REQ_SBUF));
`endif

        // address channel back-pressure
        set_req(REQ_SBUF, 32'hABCD_0100, 8'd2, 4'h7);
        serve_one(5, 1'b0, 1'b0, 0, won);

        // len 0 is a single beat
        set_req(REQ_DCACHE, 32'h0000_0080, 8'd0, 4'h9);
        serve_one(1, 1'b0, 1'b0, 0, won);

        // requester withdraws valid after latch; burst still completes
        set_req(REQ_ICACHE, 32'h0000_0800, 8'd3, 4'h4);
        serve_one(0, 1'b1, 1'b0, 0, won);

        // reset mid-burst after beat 2 of 4
        set_req(REQ_ICACHE, 32'h0000_0C00, 8'd4, 4'h5);
        serve_one(0, 1'b0, 1'b0, 2, won);

        // all three requesting continuously, from a fresh pointer
        set_req(REQ_DCACHE, $urandom, 8'd1, 4'hA);
        set_req(REQ_ICACHE, $urandom, 8'd2, 4'hB);
        set_req(REQ_SBUF,   $urandom, 8'd1, 4'hC);
        for (int i = 0; i < 4; i++) begin
            serve_one(0, 1'b0, 1'b1, 0, won);
`ifdef ARB_ROUND_ROBIN_EN
            check("rr_order", 64'(won), 64'(rr_exp[i]));
`else
            check("fixed_order", 64'(won), 64'(REQ_DCACHE));
`endif
        end
        req_arvalid = '0;

        // randomized traffic
        for (int it = 0; it < 20; it++) begin
            for (int r = 0; r < 3; r++)
                if ($urandom_range(0, 1) == 1)
                    set_req(r, $urandom, 8'($urandom_range(0, 6)), 4'($urandom));
            if (req_arvalid == '0)
                set_req(int'($urandom_range(0, 2)), $urandom, 8'($urandom_range(0, 6)), 4'($urandom));
            n = 0;
            while (req_arvalid != '0 && n < 6) begin
                serve_one(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          (n < 3) && ($urandom_range(0, 3) == 0), 0, won);
                n++;
            end
            req_arvalid = '0;
            @(negedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
